handshake_count_source: RTL

HANDSHAKE_COUNT_SOURCE -- requirements
Module: handshake_count_source

---
 rtl/handshake_count_source.sv | 106 ++++++++++
 1 files changed

// File: rtl/handshake_count_source.sv
// Valid/ready counting source: on start, offers 0..LIMIT-1 one word per accepted transfer,
// counting stalled cycles. Define HANDSHAKE_SOURCE_PROPERTIES_EN to compile in the SVA properties.
module handshake_count_source #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned LIMIT = 5
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             start,
   input  logic             ready,
   output logic             valid,
   output logic [WIDTH-1:0] data,
   output logic             done,
   output logic [WIDTH-1:0] stall_count
);

   localparam logic [WIDTH-1:0] LAST_WORD = WIDTH'(LIMIT - 1);
   localparam logic [WIDTH-1:0] STALL_MAX = {WIDTH{1'b1}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] data_nxt;
   logic [WIDTH-1:0] stall_nxt;
   logic             valid_nxt;
   logic             done_nxt;

   // State and registered outputs; reset wins over start/ready at the same edge.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state       <= IDLE;
         valid       <= 1'b0;
         done        <= 1'b0;
         data        <= '0;
         stall_count <= '0;
      end else begin
         state       <= state_nxt;
         valid       <= valid_nxt;
         done        <= done_nxt;
         data        <= data_nxt;
         stall_count <= stall_nxt;
      end
   end

   // Next state and next output values.
   always_comb begin
      state_nxt = state;
      data_nxt  = data;
      stall_nxt = stall_count;
      valid_nxt = 1'b0;
      done_nxt  = 1'b0;

      case (state)
         IDLE, DONE: begin
            if (start) begin
               state_nxt = SEND;
               data_nxt  = '0;
               stall_nxt = '0;
            end
         end
         SEND: begin
            if (ready) begin
               if (data == LAST_WORD) begin
                  state_nxt = DONE;
               end else begin
                  data_nxt = data + WIDTH'(1);
               end
            end else if (stall_count != STALL_MAX) begin
               stall_nxt = stall_count + WIDTH'(1);
            end
         end
         default: begin
            state_nxt = IDLE;
            data_nxt  = '0;
            stall_nxt = '0;
         end
      endcase

      valid_nxt = (state_nxt == SEND);
      done_nxt  = (state_nxt == DONE);
   end

`ifdef HANDSHAKE_SOURCE_PROPERTIES_EN
   // Offered word must be held until accepted.
   p_stable: assert property (@(posedge clock) disable iff (!reset_n)
      (valid && !ready) |=> ($stable(data) && valid));

   p_bound: assert property (@(posedge clock) disable iff (!reset_n)
      data <= LAST_WORD);

   p_no_valid_done: assert property (@(posedge clock) disable iff (!reset_n)
      !(done && valid));

   // Liveness only holds if downstream eventually accepts, infinitely often.
   a_ready_fair: assume property (@(posedge clock) s_eventually ready);

   p_done_live: assert property (@(posedge clock) disable iff (!reset_n)
      ((state == IDLE) && start) |-> s_eventually done);
`endif

endmodule
